// File: rtl/unified_mem_arbiter_if.sv
// Requester/RAM bundle for unified_mem_arbiter: master is the arbiter view,
// slave is the view of the pipeline stages and RAM that surround it.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  logic              stall;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata, ram_ack,
    output if_rdata, if_ack, dm_rdata, dm_ack, ram_req, ram_we, ram_addr, ram_wdata, stall
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata, ram_ack,
    input  if_rdata, if_ack, dm_rdata, dm_ack, ram_req, ram_we, ram_addr, ram_wdata, stall
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF fetches and MEM data accesses onto one single-port RAM.
// Define ARB_PERF_CNT_EN to add saturating fetch/data/conflict counters.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  unified_mem_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  data_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  if (CNT_W < 1) begin : gBadCntW
    $error("unified_mem_arbiter: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } stateT;

  stateT state;
  stateT nextState;
  logic  lastGrant;  // 0 = IF won last, 1 = DM won last
  logic  ifElig;
  logic  dmElig;
  logic  grantIf;
  logic  grantDm;
  logic  doneIf;
  logic  doneDm;

  // A requester whose ack is high this cycle has just been served; masking it
  // keeps the ack cycle from re-granting the same request.
  assign ifElig    = bus.if_req & ~bus.if_ack;
  assign dmElig    = bus.dm_req & ~bus.dm_ack;
  assign bus.stall = ifElig | dmElig;

  always_comb begin
    nextState = state;
    grantIf   = 1'b0;
    grantDm   = 1'b0;
    doneIf    = 1'b0;
    doneDm    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dmElig && (!ifElig || !lastGrant)) begin
          grantDm   = 1'b1;
          nextState = DATA;
        end else if (ifElig) begin
          grantIf   = 1'b1;
          nextState = FETCH;
        end
      end
      DATA: begin
        if (bus.ram_ack) begin
          doneDm    = 1'b1;
          nextState = IDLE;
        end
      end
      FETCH: begin
        if (bus.ram_ack) begin
          doneIf    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lastGrant     <= 1'b1;
      bus.ram_req   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.dm_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      state      <= nextState;
      bus.if_ack <= doneIf;
      bus.dm_ack <= doneDm;
      if (grantIf) begin
        lastGrant     <= 1'b0;
        bus.ram_req   <= 1'b1;
        bus.ram_we    <= 1'b0;
        bus.ram_addr  <= bus.if_addr;
        bus.ram_wdata <= '0;
      end else if (grantDm) begin
        lastGrant     <= 1'b1;
        bus.ram_req   <= 1'b1;
        bus.ram_we    <= bus.dm_we;
        bus.ram_addr  <= bus.dm_addr;
        bus.ram_wdata <= bus.dm_wdata;
      end else if (doneIf || doneDm) begin
        bus.ram_req <= 1'b0;
      end
      if (doneIf) begin
        bus.if_rdata <= bus.ram_rdata;
      end
      // ram_we still reflects the finishing transaction; stores keep dm_rdata
      if (doneDm && !bus.ram_we) begin
        bus.dm_rdata <= bus.ram_rdata;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt    <= '0;
      data_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (bus.if_ack) fetch_cnt <= satInc(fetch_cnt);
      if (bus.dm_ack) data_cnt  <= satInc(data_cnt);
      if (state == IDLE && ifElig && dmElig) conflict_cnt <= satInc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: reset, fetch, conflict, store,
// alternating back-to-back grants and reset during a pending fetch.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   nTests = 0;
  int   nFail  = 0;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [15:0] fetchCnt;
  logic [15:0] dataCnt;
  logic [15:0] conflictCnt;
`endif

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .fetch_cnt    (fetchCnt),
    .data_cnt     (dataCnt),
    .conflict_cnt (conflictCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] expAddr;
    logic [31:0] expData;
    rst           = 1'b1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h10;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.ram_rdata = '0;
    bus.ram_ack   = 1'b0;

    // 1: reset with a fetch pending, then release
    tick();
    tick();
    check("rst ram_req", {31'd0, bus.ram_req}, 32'd0);
    check("rst ram_we", {31'd0, bus.ram_we}, 32'd0);
    check("rst ram_addr", bus.ram_addr, 32'd0);
    check("rst ram_wdata", bus.ram_wdata, 32'd0);
    check("rst if_ack", {31'd0, bus.if_ack}, 32'd0);
    check("rst dm_ack", {31'd0, bus.dm_ack}, 32'd0);
    check("rst if_rdata", bus.if_rdata, 32'd0);
    check("rst dm_rdata", bus.dm_rdata, 32'd0);
    rst = 1'b0;
    tick();
    check("rel ram_req", {31'd0, bus.ram_req}, 32'd1);
    check("rel ram_addr", bus.ram_addr, 32'h10);
    check("rel ram_we", {31'd0, bus.ram_we}, 32'd0);

    // 2: that fetch completes after 3 ram_req cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      check("fetch wait ram_req", {31'd0, bus.ram_req}, 32'd1);
      check("fetch wait if_ack", {31'd0, bus.if_ack}, 32'd0);
      check("fetch wait stall", {31'd0, bus.stall}, 32'd1);
    end
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h00500093;
    #1;
    check("fetch pre-ack stall", {31'd0, bus.stall}, 32'd1);
    tick();
    check("fetch if_ack", {31'd0, bus.if_ack}, 32'd1);
    check("fetch if_rdata", bus.if_rdata, 32'h00500093);
    check("fetch ack stall", {31'd0, bus.stall}, 32'd0);
    check("fetch ack ram_req", {31'd0, bus.ram_req}, 32'd0);
    bus.if_req  = 1'b0;
    bus.ram_ack = 1'b0;
    tick();
    check("fetch single pulse", {31'd0, bus.if_ack}, 32'd0);
    check("fetch rdata hold", bus.if_rdata, 32'h00500093);
    check("fetch idle ram_req", {31'd0, bus.ram_req}, 32'd0);

    // 3: simultaneous fetch and load after reset, IF wins the tie
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h80;
    tick();
    check("conf first addr", bus.ram_addr, 32'h20);
    check("conf first we", {31'd0, bus.ram_we}, 32'd0);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h11111111;
    tick();
    check("conf if_ack", {31'd0, bus.if_ack}, 32'd1);
    check("conf no dm_ack", {31'd0, bus.dm_ack}, 32'd0);
    check("conf if_rdata", bus.if_rdata, 32'h11111111);
    check("conf dm stall", {31'd0, bus.stall}, 32'd1);
    bus.if_req  = 1'b0;
    bus.ram_ack = 1'b0;
    tick();
    check("conf second req", {31'd0, bus.ram_req}, 32'd1);
    check("conf second addr", bus.ram_addr, 32'h80);
    check("conf if_ack once", {31'd0, bus.if_ack}, 32'd0);
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h22222222;
    tick();
    check("conf dm_ack", {31'd0, bus.dm_ack}, 32'd1);
    check("conf dm_rdata", bus.dm_rdata, 32'h22222222);
    bus.dm_req  = 1'b0;
    bus.ram_ack = 1'b0;
    tick();
    check("conf dm_ack once", {31'd0, bus.dm_ack}, 32'd0);
    check("conf idle ram_req", {31'd0, bus.ram_req}, 32'd0);
`ifdef ARB_PERF_CNT_EN
    check("conf conflict_cnt", {16'd0, conflictCnt}, 32'd1);
    check("conf fetch_cnt", {16'd0, fetchCnt}, 32'd1);
    check("conf data_cnt", {16'd0, dataCnt}, 32'd1);
`endif

    // 4: store holds its RAM fields and leaves dm_rdata alone
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 2; i++) begin
      check("store ram_req", {31'd0, bus.ram_req}, 32'd1);
      check("store ram_we", {31'd0, bus.ram_we}, 32'd1);
      check("store ram_addr", bus.ram_addr, 32'h40);
      check("store ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
      if (i == 0) tick();
    end
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'hBADBAD00;
    tick();
    check("store dm_ack", {31'd0, bus.dm_ack}, 32'd1);
    check("store dm_rdata kept", bus.dm_rdata, 32'h22222222);
    bus.dm_req  = 1'b0;
    bus.dm_we   = 1'b0;
    bus.ram_ack = 1'b0;
    tick();
    check("store dm_ack once", {31'd0, bus.dm_ack}, 32'd0);

    // 5: both keep requesting; grants alternate IF,DM,IF,DM
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h200;
    bus.ram_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expAddr = (i % 2 == 0) ? 32'h100 : 32'h200;
      expData = 32'hA0 + i;
      check("b2b ram_req", {31'd0, bus.ram_req}, 32'd1);
      check("b2b ram_addr", bus.ram_addr, expAddr);
      check("b2b no ack", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
      bus.ram_rdata = expData;
      if (i == 3) bus.if_req = 1'b0;
      tick();
      if (i % 2 == 0) begin
        check("b2b acks IF", {30'd0, bus.if_ack, bus.dm_ack}, 32'd2);
        check("b2b if_rdata", bus.if_rdata, expData);
      end else begin
        check("b2b acks DM", {30'd0, bus.if_ack, bus.dm_ack}, 32'd1);
        check("b2b dm_rdata", bus.dm_rdata, expData);
      end
    end
    bus.dm_req  = 1'b0;
    bus.ram_ack = 1'b0;
    tick();
    check("b2b done ram_req", {31'd0, bus.ram_req}, 32'd0);
    check("b2b done acks", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);

    // 6: reset while a fetch is pending, late ram_ack must be ignored
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    tick();
    check("mid ram_req", {31'd0, bus.ram_req}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid rst ram_req", {31'd0, bus.ram_req}, 32'd0);
    check("mid rst if_ack", {31'd0, bus.if_ack}, 32'd0);
    check("mid rst if_rdata", bus.if_rdata, 32'd0);
    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h55555555;
    tick();
    check("mid late if_ack", {31'd0, bus.if_ack}, 32'd0);
    check("mid late ram_req", {31'd0, bus.ram_req}, 32'd0);
    bus.ram_ack = 1'b0;
    tick();
    check("mid after if_ack", {31'd0, bus.if_ack}, 32'd0);
    check("mid after ram_req", {31'd0, bus.ram_req}, 32'd0);
    check("mid after if_rdata", bus.if_rdata, 32'd0);
    check("mid after stall", {31'd0, bus.stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
